fetch_controller: RTL and testbench

Sequencer for the byte-addressed `instruction_memory` in the 4-stage pipeline. It:
- owns the program counter and issues one-word read requests;
- tracks the single in-flight registered response;
- buffers returned instructions in a 2-entry queue so decode back-pressure never loses a word.

It handles branch redirects by squashing in-flight and queued words, and it halts on misaligned or out-of-range fetch addresses.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_controller.sv | 135 +++++++++++++
 tb/tb_fetch_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction fetch path
package imem_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int QUEUE_DEPTH = 2;
  localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1);

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A fetch address is usable when word aligned and the whole word lies inside memory.
  function automatic logic pc_is_legal(input logic [31:0] pc, input logic [31:0] mem_bytes);
    return (pc[1:0] == 2'b00) && (pc <= (mem_bytes - WORD_STRIDE));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {pc, instr} FIFO with synchronous flush
module fetch_queue
  import imem_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     entry_q [QUEUE_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Status flags and qualified push/pop; a push into a full queue is only taken alongside a pop.
  always_comb begin
    full_o  = (count_q == CNT_W'(QUEUE_DEPTH));
    empty_o = (count_q == '0);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    head_o  = entry_q[rd_ptr_q];
    count_o = count_q;
  end

  // Storage, pointers and occupancy; flush empties the queue but leaves stale data in place.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        entry_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencer, request credit, redirect squash and fault halt
module fetch_controller
  import imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_rd_addr,
  output logic        imem_rd_en,
  output logic        imem_fetch,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        addr_fault
);

  localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic             inflight_q;
  logic [31:0]      inflight_pc_q;
  logic             squash_q;

  logic             pc_ok;
  logic             redirect_ok;
  logic             pop;
  logic             push;
  logic             credit_ok;
  logic             issue;
  logic [CNT_W:0]   demand;
  logic [CNT_W:0]   limit;
  fetch_entry_t     push_entry;
  fetch_entry_t     q_head;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;

  // Legality, handshake and credit: words owed to the queue must fit after this cycle's pop.
  always_comb begin
    pc_ok       = pc_is_legal(pc_q, MEM_BYTES_W);
    redirect_ok = pc_is_legal(redirect_pc, MEM_BYTES_W);
    pop         = ~q_empty & ~stall;
    push        = inflight_q & ~squash_q & ~redirect_valid;
    demand      = {1'b0, q_count} + (CNT_W + 1)'(inflight_q);
    limit       = (CNT_W + 1)'(QUEUE_DEPTH) + (CNT_W + 1)'(pop);
    credit_ok   = (demand < limit) & ~(q_full & ~pop);
    push_entry  = '{pc: inflight_pc_q, instr: imem_instr};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect overrides everything, including START.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = redirect_ok ? RUN : FAULT;
    end else begin
      unique case (state_q)
        START:   state_d = RUN;
        RUN:     if (!pc_ok) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = START;
      endcase
    end
  end

  // Outputs: request only in RUN with a legal PC, credit, and no redirect this cycle.
  always_comb begin
    issue        = (state_q == RUN) & ~redirect_valid & pc_ok & credit_ok;
    imem_rd_en   = issue;
    imem_fetch   = issue;
    imem_rd_addr = pc_q;
    addr_fault   = (state_q == FAULT);
    if_valid     = ~q_empty;
    if_pc        = q_head.pc;
    if_instr     = q_head.instr;
  end

  // Next PC: redirect target wins, otherwise advance one word per issued request.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + WORD_STRIDE;
    end
  end

  // PC, in-flight tracking and squash flag for a response that must be dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      squash_q   <= redirect_valid;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
    end
  end

  fetch_queue u_queue (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_rd_addr;
  logic        imem_rd_en;
  logic        imem_fetch;
  logic [31:0] imem_instr = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        addr_fault;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mem [32];

  fetch_controller #(.RESET_PC(32'h0), .MEM_BYTES(128)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd_addr   (imem_rd_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_fetch     (imem_fetch),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .addr_fault     (addr_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_instr <= mem[imem_rd_addr[6:2]];
  end

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'd124);
  endfunction

  task automatic start_run();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (imem_rd_addr !== 32'h0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", imem_rd_addr); end
    checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    checks++; if (imem_fetch !== 1'b0) begin failures++; $display("FAIL reset_fetch got=%b exp=0", imem_fetch); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%h exp=0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
    checks++; if (addr_fault !== 1'b0) begin failures++; $display("FAIL reset_addr_fault got=%b exp=0", addr_fault); end
  endtask

  task automatic test_stream();
    start_run(); #1;
    checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL stream_start_rd_en got=%b exp=0", imem_rd_en); end
    for (int c = 1; c <= 6; c++) begin
      next_cycle(); #1;
      if (c <= 4) begin
        checks++; if (imem_rd_en !== 1'b1) begin failures++; $display("FAIL stream_rd_en c=%0d got=%b exp=1", c, imem_rd_en); end
      end
      checks++; if (if_valid !== (c >= 3)) begin failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, if_valid, c >= 3); end
      if (c >= 3) begin
        checks++; if (if_pc !== 32'(4 * (c - 3))) begin failures++; $display("FAIL stream_pc c=%0d got=%h exp=%h", c, if_pc, 4 * (c - 3)); end
        checks++; if (if_instr !== mem[c - 3]) begin failures++; $display("FAIL stream_instr c=%0d got=%h exp=%h", c, if_instr, mem[c - 3]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    start_run();
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      stall = (c >= 4 && c <= 8);
      #1;
      if (c >= 4 && c <= 8) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd4) begin failures++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/4", c, if_valid, if_pc); end
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL stall_rd_en c=%0d got=%b exp=0", c, imem_rd_en); end
      end
      if (c >= 9) begin
        exp_pc = 32'(4 * (c - 8));
        checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin failures++; $display("FAIL stall_drain c=%0d got=%b/%h exp=1/%h", c, if_valid, if_pc, exp_pc); end
        checks++; if (if_instr !== mem[exp_pc[6:2]]) begin failures++; $display("FAIL stall_instr c=%0d got=%h exp=%h", c, if_instr, mem[exp_pc[6:2]]); end
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_squash();
    start_run();
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      redirect_valid = (c == 3);
      redirect_pc    = 32'd12;
      stall          = (c == 3);
      #1;
      case (c)
        3: begin
          checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL squash_no_req got=%b exp=0", imem_rd_en); end
        end
        4: begin
          checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL squash_flush got=%b exp=0", if_valid); end
          checks++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 32'd12) begin failures++; $display("FAIL squash_req got=%b/%h exp=1/c", imem_rd_en, imem_rd_addr); end
        end
        5: begin
          checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL squash_drop got=%b exp=0", if_valid); end
        end
        6: begin
          checks++; if (if_valid !== 1'b1 || if_pc !== 32'd12 || if_instr !== 32'h0002356a) begin
            failures++; $display("FAIL squash_target got=%b/%h/%h exp=1/c/0002356a", if_valid, if_pc, if_instr); end
        end
        7: begin
          checks++; if (if_valid !== 1'b1 || if_pc !== 32'd16) begin failures++; $display("FAIL squash_next got=%b/%h exp=1/10", if_valid, if_pc); end
        end
        default: ;
      endcase
    end
    redirect_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic test_fault_redirect();
    start_run();
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      redirect_valid = (c == 5 || c == 9);
      redirect_pc    = (c == 5) ? 32'h6 : 32'h8;
      #1;
      if (c == 5) begin
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL fault_no_req got=%b exp=0", imem_rd_en); end
      end
      if (c >= 6 && c <= 9) begin
        checks++; if (addr_fault !== 1'b1 || imem_rd_en !== 1'b0) begin failures++; $display("FAIL fault_held c=%0d got=%b/%b exp=1/0", c, addr_fault, imem_rd_en); end
      end
      if (c == 6) begin
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fault_flush got=%b exp=0", if_valid); end
      end
      if (c == 10) begin
        checks++; if (addr_fault !== 1'b0 || imem_rd_en !== 1'b1 || imem_rd_addr !== 32'd8) begin
          failures++; $display("FAIL fault_clear got=%b/%b/%h exp=0/1/8", addr_fault, imem_rd_en, imem_rd_addr); end
      end
      if (c == 12) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd8 || if_instr !== 32'h0001a507) begin
          failures++; $display("FAIL fault_deliver got=%b/%h/%h exp=1/8/0001a507", if_valid, if_pc, if_instr); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_end_of_memory();
    logic [31:0] exp_pc;
    int delivered;
    exp_pc = 32'h0; delivered = 0;
    start_run();
    for (int c = 1; c <= 45; c++) begin
      next_cycle(); #1;
      if (if_valid) begin
        delivered++;
        checks++; if (if_pc !== exp_pc || if_instr !== mem[exp_pc[6:2]]) begin
          failures++; $display("FAIL eom_word got=%h/%h exp=%h/%h", if_pc, if_instr, exp_pc, mem[exp_pc[6:2]]); end
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_rd_en && imem_rd_addr > 32'd124) begin
        checks++; failures++; $display("FAIL eom_req_range got=%h exp<=7c", imem_rd_addr);
      end
      if (c == 33) begin
        checks++; if (imem_rd_addr !== 32'd128 || imem_rd_en !== 1'b0 || addr_fault !== 1'b0) begin
          failures++; $display("FAIL eom_pc128 got=%h/%b/%b exp=80/0/0", imem_rd_addr, imem_rd_en, addr_fault); end
      end
      if (c == 34) begin
        checks++; if (addr_fault !== 1'b1) begin failures++; $display("FAIL eom_fault_rise got=%b exp=1", addr_fault); end
      end
    end
    checks++; if (delivered != 32) begin failures++; $display("FAIL eom_count got=%0d exp=32", delivered); end
    checks++; if (addr_fault !== 1'b1 || imem_rd_en !== 1'b0) begin failures++; $display("FAIL eom_final got=%b/%b exp=1/0", addr_fault, imem_rd_en); end
  endtask

  task automatic test_reset_midstream();
    start_run();
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      stall = (c == 4);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (imem_rd_addr !== 32'h0 || imem_rd_en !== 1'b0 || imem_fetch !== 1'b0) begin
      failures++; $display("FAIL midrst_req got=%h/%b/%b exp=0/0/0", imem_rd_addr, imem_rd_en, imem_fetch); end
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || addr_fault !== 1'b0) begin
      failures++; $display("FAIL midrst_if got=%b/%h/%h/%b exp=0/0/0/0", if_valid, if_pc, if_instr, addr_fault); end
    start_run();
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); #1;
      if (c == 1) begin
        checks++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 32'h0) begin failures++; $display("FAIL midrst_refetch got=%b/%h exp=1/0", imem_rd_en, imem_rd_addr); end
      end
      checks++; if (if_valid !== (c == 3)) begin failures++; $display("FAIL midrst_valid c=%0d got=%b exp=%b", c, if_valid, c == 3); end
      if (c == 3) begin
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h00008c41) begin failures++; $display("FAIL midrst_word got=%h/%h exp=0/00008c41", if_pc, if_instr); end
      end
    end
  endtask

  task automatic test_redirect_start();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; cyc = 0;
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL start_redir_no_req got=%b exp=0", imem_rd_en); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      redirect_valid = 1'b0;
      #1;
      if (c == 1) begin
        checks++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 32'd8) begin failures++; $display("FAIL start_redir_req got=%b/%h exp=1/8", imem_rd_en, imem_rd_addr); end
      end
      if (c == 3) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd8 || if_instr !== 32'h0001a507) begin
          failures++; $display("FAIL start_redir_word got=%b/%h/%h exp=1/8/0001a507", if_valid, if_pc, if_instr); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] target;
    bit          fault_pending;
    bit          fault_exp;
    int          streak;
    int          r;
    exp_pc = 32'h0; fault_pending = 0; fault_exp = 0; streak = 0;
    start_run();
    for (int c = 1; c <= 600; c++) begin
      next_cycle();
      stall = ($urandom % 4 == 0);
      redirect_valid = ($urandom % 14 == 0);
      r = int'($urandom % 8);
      if (r == 0)      target = 32'(($urandom % 32) * 4 + ($urandom % 3) + 1);
      else if (r == 1) target = 32'd128 + 32'(($urandom % 8) * 4);
      else             target = 32'(($urandom % 32) * 4);
      redirect_pc = target;
      #1;
      checks++; if (imem_rd_en !== imem_fetch) begin failures++; $display("FAIL rnd_fetch_alias got=%b exp=%b", imem_fetch, imem_rd_en); end
      if (imem_rd_en && !legal(imem_rd_addr)) begin
        checks++; failures++; $display("FAIL rnd_req_legal got=%h exp=legal", imem_rd_addr);
      end
      if (fault_pending) begin
        checks++; if (addr_fault !== fault_exp) begin failures++; $display("FAIL rnd_fault c=%0d got=%b exp=%b", c, addr_fault, fault_exp); end
        fault_pending = 0;
      end
      if (redirect_valid) begin
        exp_pc = target; streak = 0;
        fault_pending = 1; fault_exp = !legal(target);
      end else if (if_valid && !stall) begin
        checks++; if (if_pc !== exp_pc || if_instr !== mem[exp_pc[6:2]]) begin
          failures++; $display("FAIL rnd_word c=%0d got=%h/%h exp=%h/%h", c, if_pc, if_instr, exp_pc, mem[exp_pc[6:2]]); end
        exp_pc = exp_pc + 32'd4; streak = 0;
      end else if (!stall && legal(exp_pc)) begin
        streak++;
        if (streak > 3) begin
          checks++; failures++; $display("FAIL rnd_progress c=%0d got=no_word exp=%h", c, exp_pc);
          streak = 0;
        end
      end
    end
    stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    mem[0] = 32'h00008c41;
    mem[1] = 32'h000118a4;
    mem[2] = 32'h0001a507;
    mem[3] = 32'h0002356a;
    for (int i = 4; i < 32; i++) mem[i] = $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_squash();
    test_fault_redirect();
    test_end_of_memory();
    test_reset_midstream();
    test_redirect_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
